// File: rtl/demux_pkg.sv
// Shared types and constants for the demux frame router and its shifter.
package demux_pkg;
  localparam int NUM_CH     = 8;
  localparam int DEST_W     = 3;
  localparam int DATA_W_DEF = 8;

  // Bit-counter width wide enough for DATA_W payload bits plus an optional parity bit.
  function automatic int cnt_w_f(input int data_w);
    return $clog2(data_w + 2);
  endfunction

  localparam int CNT_W = cnt_w_f(DATA_W_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } router_state_t;
endpackage

// File: rtl/demux_frame_router_if.sv
// Upstream word interface of the demux frame router: {dest, data} over valid/ready.
interface demux_frame_router_if #(
  parameter int DATA_W = 8
);
  import demux_pkg::*;

  // A word transfers on a rising edge where in_valid && in_ready; the master holds
  // in_valid/in_dest/in_data stable until then, and in_ready never depends on in_valid.
  logic              in_valid;
  logic              in_ready;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_dest, output in_data, input in_ready);
  modport slave  (input in_valid, input in_dest, input in_data, output in_ready);
endinterface

// File: rtl/demux_frame_shifter.sv
// LSB-first shift register with bit counter; appends an even-parity bit after the MSB
// when DEMUX_ROUTER_PARITY_EN is defined.
module demux_frame_shifter
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              ser_bit,
  output logic              last
);
`ifdef DEMUX_ROUTER_PARITY_EN
  localparam int N = DATA_W + 1;
`else
  localparam int N = DATA_W;
`endif
  localparam int CW = cnt_w_f(DATA_W);

  logic [N-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over shift so a back-to-back reload replaces the finishing frame.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
`ifdef DEMUX_ROUTER_PARITY_EN
      sh_d = {^data, data};
`else
      sh_d = data;
`endif
      cnt_d = '0;
    end else if (shift) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign ser_bit = sh_q[0];
  assign last    = (cnt_q == CW'(N - 1));
endmodule

// File: rtl/demux_frame_router.sv
// Frame router feeding the 1-to-8 demux: 1-deep pending word, serialiser FSM, gap timer.
// Optional even-parity bit per frame via DEMUX_ROUTER_PARITY_EN (handled in the shifter).
module demux_frame_router
  import demux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_frame_router_if.slave  up,
  output logic                 a,
  output logic [DEST_W-1:0]    s,
  output logic                 bit_valid,
  output logic                 busy,
  output logic                 frame_done,
  output router_state_t        dbg_state
);
  router_state_t     state_q, state_d;
  logic              pend_full_q, pend_full_d;
  logic [DEST_W-1:0] pend_dest_q, pend_dest_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DEST_W-1:0] s_q, s_d;
  logic [3:0]        gap_q, gap_d;
  logic              fd_q, fd_d;
  logic              rdy_q, rdy_d;
  logic              load, shift, ser_bit, last, accept;

  assign accept = up.in_valid && rdy_q;

  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_dest_d = pend_dest_q;
    pend_data_d = pend_data_q;
    s_d         = s_q;
    gap_d       = gap_q;
    fd_d        = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          load    = 1'b1;
          s_d     = pend_dest_q;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          fd_d = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = 4'(GAP_CYC - 1);
          end else if (pend_full_q) begin
            load = 1'b1;
            s_d  = pend_dest_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // accept and load never coincide: accept needs rdy_q, which is low while pending is full.
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_dest_d = up.in_dest;
      pend_data_d = up.in_data;
    end
    rdy_d = !pend_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      pend_dest_q <= '0;
      pend_data_q <= '0;
      s_q         <= '0;
      gap_q       <= '0;
      fd_q        <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_dest_q <= pend_dest_d;
      pend_data_q <= pend_data_d;
      s_q         <= s_d;
      gap_q       <= gap_d;
      fd_q        <= fd_d;
      rdy_q       <= rdy_d;
    end
  end

  demux_frame_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .data    (pend_data_q),
    .ser_bit (ser_bit),
    .last    (last)
  );

  assign bit_valid   = (state_q == SHIFT);
  assign a           = bit_valid & ser_bit;
  assign s           = s_q;
  assign busy        = (state_q != IDLE) || pend_full_q;
  assign frame_done  = fd_q;
  assign up.in_ready = rdy_q;
  assign dbg_state   = state_q;
endmodule
